// File: rtl/fetch_buffer.sv
// Instruction prefetch stage: owns the fetch PC, issues one outstanding memory
// request at a time and queues fetched {pc, inst} pairs for decode.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req,
    output logic [15:0]            mem_addr,
    input  logic                   mem_ready,
    input  logic [15:0]            mem_data,
    output logic                   out_valid,
    output logic [15:0]            out_inst,
    output logic [15:0]            out_pc,
    input  logic                   out_ready,
    input  logic                   redirect,
    input  logic [15:0]            redirect_pc,
    input  logic                   stop,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t         state_q;
    logic [15:0]    fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    slot_pc_q   [DEPTH];
    logic [15:0]    slot_inst_q [DEPTH];

    logic           push;
    logic           pop;
    logic [CW-1:0]  cnt_pp;
    logic           issue_idle;
    logic           issue_wait;

    assign mem_req   = (state_q == REQ);
    assign mem_addr  = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = slot_pc_q[rd_q];
    assign out_inst  = slot_inst_q[rd_q];
    assign count     = count_q;

    assign push   = (state_q == WAIT) && mem_ready && !redirect;
    assign pop    = out_valid && out_ready;
    assign cnt_pp = count_q - CW'(pop);

    // Room is reserved when the request is issued, so the response can always be pushed.
    assign issue_idle = !stop && (cnt_pp < CW'(DEPTH));
    assign issue_wait = !stop && (cnt_pp < CW'(DEPTH - 1));

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wr_d       = '0;
            rd_d       = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_d       = wr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 16'd1;
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_q[i]   <= '0;
                slot_inst_q[i] <= '0;
            end
        end else if (push) begin
            slot_pc_q[wr_q]   <= fetch_pc_q;
            slot_inst_q[wr_q] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (redirect) begin
            // Any request still in flight must be drained in DROP before refetching;
            // a response landing in DROP alongside a new redirect settles the debt.
            case (state_q)
                IDLE:    state_q <= IDLE;
                REQ:     state_q <= DROP;
                WAIT:    state_q <= mem_ready ? IDLE : DROP;
                DROP:    state_q <= mem_ready ? IDLE : DROP;
                default: state_q <= IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE:    state_q <= issue_idle ? REQ : IDLE;
                REQ:     state_q <= WAIT;
                WAIT: begin
                    if (mem_ready) begin
                        state_q <= issue_wait ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (mem_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: variable-latency memory responder plus
// hand-computed expectations for streaming, backpressure, redirect, stop and reset.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic        out_valid;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic        out_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        stop = 1'b0;
    logic [2:0]  count;

    int          total = 0;
    int          bad = 0;
    int          lat = 2;
    bit          mem_flush = 1'b0;
    int          cd = 0;
    logic [15:0] paddr = 16'h0000;
    logic [15:0] req_log[$];

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .out_valid  (out_valid),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_ready  (out_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stop       (stop),
        .count      (count)
    );

    // Memory: answers a request seen in cycle k with a one-cycle ready in cycle k+lat.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_flush) begin
                cd = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_ready = 1'b1;
                    mem_data  = 16'h1000 + paddr;
                end
            end
            if (mem_req) begin
                cd    = lat;
                paddr = mem_addr;
                req_log.push_back(mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        mem_flush = 1'b1;
        redirect  = 1'b0;
        stop      = 1'b0;
        step();
        step();
        rst_n     = 1'b1;
        mem_flush = 1'b0;
        req_log.delete();
    endtask

    task automatic wait_req(input int n, input int lim, input string tag);
        for (int i = 0; i < lim && req_log.size() < n; i++) step();
        chk(tag, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input int lim, input string tag);
        for (int i = 0; i < lim && !out_valid; i++) step();
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    function automatic logic [31:0] logged(input int i);
        if (i < req_log.size()) return 32'(req_log[i]);
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        int  npop;
        int  exp_pc;
        int  maxc;
        bit  saw_rdy;
        bit  prev_rdy;

        // Reset state and streaming with a 2-cycle memory
        out_ready = 1'b0;
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_pc", 32'(out_pc), 32'h0);
        chk("rst_inst", 32'(out_inst), 32'h0);

        out_ready = 1'b1;
        lat = 2;
        npop = 0;
        exp_pc = 0;
        maxc = 0;
        for (int c = 0; c < 80 && npop < 4; c++) begin
            step();
            if (int'(count) > maxc) maxc = int'(count);
            if (out_valid && out_ready) begin
                chk("t1_pc", 32'(out_pc), 32'(exp_pc));
                chk("t1_inst", 32'(out_inst), 32'(16'h1000 + exp_pc));
                exp_pc++;
                npop++;
            end
        end
        chk("t1_npops", 32'(npop), 32'd4);
        chk("t1_maxcnt", 32'(maxc), 32'd1);
        for (int i = 0; i < 4; i++) chk("t1_addr", logged(i), 32'(i));

        // Backpressure: FIFO fills to DEPTH and fetching stops
        out_ready = 1'b0;
        do_reset();
        repeat (40) step();
        chk("t2_nreq", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_addr", logged(i), 32'(i));
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_memreq", 32'(mem_req), 32'd0);
        chk("t2_head_pc", 32'(out_pc), 32'h0);
        chk("t2_head_inst", 32'(out_inst), 32'h1000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_cnt_pop", 32'(count), 32'd3);
        chk("t2_head2_pc", 32'(out_pc), 32'h1);
        chk("t2_memreq2", 32'(mem_req), 32'd1);
        chk("t2_addr4", 32'(mem_addr), 32'h4);

        // Redirect while waiting on addr 2: response owed, dropped, then refetch
        out_ready = 1'b0;
        lat = 4;
        do_reset();
        wait_req(3, 40, "t3_req2_seen");
        chk("t3_req2_addr", 32'(mem_addr), 32'h2);
        step();
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("t3_count", 32'(count), 32'd0);
        chk("t3_valid", 32'(out_valid), 32'd0);
        chk("t3_memreq", 32'(mem_req), 32'd0);
        saw_rdy = 1'b0;
        prev_rdy = 1'b0;
        for (int i = 0; i < 20 && !mem_req; i++) begin
            step();
            if (prev_rdy) chk("t3_nopush", 32'(count), 32'd0);
            prev_rdy = mem_ready;
            if (mem_ready) saw_rdy = 1'b1;
        end
        chk("t3_rdy_before_req", 32'(saw_rdy), 32'd1);
        chk("t3_req_addr", 32'(mem_addr), 32'h40);
        out_ready = 1'b1;
        wait_valid(20, "t3_valid_again");
        chk("t3_out_pc", 32'(out_pc), 32'h40);
        chk("t3_out_inst", 32'(out_inst), 32'h1040);

        // Redirect coinciding with the response for addr 5
        out_ready = 1'b1;
        lat = 2;
        do_reset();
        wait_req(6, 60, "t4_req5_seen");
        chk("t4_req5_addr", logged(5), 32'h5);
        for (int i = 0; i < 10 && !mem_ready; i++) step();
        chk("t4_ready_seen", 32'(mem_ready), 32'd1);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("t4_memreq_c1", 32'(mem_req), 32'd0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_valid", 32'(out_valid), 32'd0);
        step();
        chk("t4_memreq_c2", 32'(mem_req), 32'd1);
        chk("t4_addr", 32'(mem_addr), 32'h40);
        wait_valid(20, "t4_valid_again");
        chk("t4_out_pc", 32'(out_pc), 32'h40);

        // stop while waiting on addr 1
        out_ready = 1'b0;
        lat = 3;
        do_reset();
        wait_req(2, 40, "t5_req1_seen");
        step();
        stop = 1'b1;
        repeat (15) step();
        chk("t5_nreq", 32'(req_log.size()), 32'd2);
        chk("t5_count", 32'(count), 32'd2);
        chk("t5_memreq", 32'(mem_req), 32'd0);
        chk("t5_head_pc", 32'(out_pc), 32'h0);
        chk("t5_head_inst", 32'(out_inst), 32'h1000);
        stop = 1'b0;
        step();
        chk("t5_resume_req", 32'(mem_req), 32'd1);
        chk("t5_resume_addr", 32'(mem_addr), 32'h2);

        // Single-cycle reset while waiting on addr 3 with 3 entries buffered
        out_ready = 1'b0;
        lat = 2;
        do_reset();
        wait_req(4, 40, "t6_req3_seen");
        step();
        chk("t6_pre_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_memreq", 32'(mem_req), 32'd0);
        chk("t6_out_pc", 32'(out_pc), 32'h0);
        step();
        chk("t6_req_again", 32'(mem_req), 32'd1);
        chk("t6_req_addr", 32'(mem_addr), 32'h0);
        chk("t6_stale_ignored", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Instruction prefetch stage that sits directly upstream of the decode/issue stage. It owns the fetch PC, drives the memory fetch port (request pulse, then ready with data), and buffers fetched {pc, inst} pairs in a small FIFO. The FIFO is presented to decode through a valid/ready handshake. Decode redirects it on jmp/jeq resolution and stops it on halt.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
RESET_PC, 16'h0000, fetch PC loaded on reset.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset.
mem_req  output  1  one-cycle fetch request to the memory fetch port.
mem_addr  output  16  fetch address; valid while mem_req=1.
mem_ready  input  1  one-cycle pulse: mem_data holds the word for the outstanding request.
mem_data  input  16  fetched instruction word.
out_valid  output  1  FIFO non-empty.
out_inst  output  16  head entry instruction.
out_pc  output  16  head entry PC.
out_ready  input  1  decode accepts the head entry this cycle.
redirect  input  1  flush the FIFO and restart fetching at redirect_pc.
redirect_pc  input  16  new fetch PC.
stop  input  1  while 1, no new mem_req is issued (halt seen).
count  output  log2(DEPTH)+1  current number of FIFO entries.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). While rst_n=0 at a posedge the block resets:
  - state IDLE, fetch_pc=RESET_PC, count=0, read and write pointers 0, all slots 0.
  - mem_req=0, out_valid=0, out_inst=0, out_pc=0.
- At most one memory request is outstanding at any time.
- FSM states: IDLE, REQ, WAIT, DROP.
  - mem_req=(state==REQ); mem_addr=fetch_pc at all times.
  - issue = !stop && (count < DEPTH). The count used here is post-pop for the current cycle.
  - IDLE: if issue, go to REQ; else stay in IDLE.
  - REQ: mem_req is high for exactly this cycle; go to WAIT unconditionally.
  - WAIT: on mem_ready:
    - push {fetch_pc, mem_data}; fetch_pc <= fetch_pc+1.
    - go to REQ if issue (evaluated with count+1), else IDLE.
    - Without mem_ready, stay in WAIT.
  - DROP: on mem_ready, discard the data and go to IDLE; else stay in DROP.
- mem_ready is ignored in IDLE and REQ.
- Space reservation: a request is issued only when the FIFO has room, and pops only free space, so a push never overflows. count never exceeds DEPTH.
- Output handshake:
  - out_valid=(count!=0). out_inst and out_pc come combinationally from the head slot.
  - Pop occurs when out_valid && out_ready.
  - Push into an empty FIFO becomes visible the next cycle; there is no bypass.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. count is tracked separately so full and empty are unambiguous.
- fetch_pc arithmetic is 16-bit; 16'hFFFF+1 wraps to 0.
- Redirect (highest priority, same edge):
  - count <= 0, pointers <= 0, fetch_pc <= redirect_pc.
  - Any push this cycle is suppressed. A pop this cycle still counts as consumed by decode but leaves no residue.
  - From WAIT without mem_ready, or from REQ: go to DROP, because a response is still owed.
  - From WAIT with mem_ready in the same cycle: discard the data and go to IDLE.
  - From IDLE: stay in IDLE.
  - From DROP: stay in DROP, taking the latest redirect_pc.
- stop: does not abort an outstanding request. A response arriving under stop is still pushed; after it the FSM goes to IDLE. Deasserting stop resumes fetching from IDLE.
- Reset mid-operation: the block returns to IDLE regardless of state. The system resets or idles memory in the same cycle; a stale mem_ready in IDLE is ignored.
- Minimum request-to-request spacing is 2 cycles (REQ, WAIT with mem_ready). With a 1-cycle-latency memory the throughput is one instruction every 2 cycles.

Test Plan:
1. Reset to RESET_PC=0; memory with 2-cycle latency returning mem[a]=16'h1000+a; out_ready=1.
   -> mem_addr sequence 0,1,2,3; decode receives (pc,inst) pairs (0,1000),(1,1001),(2,1002),(3,1003) in order; count never exceeds 1.
2. out_ready=0 from reset.
   -> exactly 4 requests (addr 0..3); count=4; no 5th mem_req.
   -> Pulse out_ready for one cycle: head (0,1000) pops, count=3, and the next mem_req has addr 4.
3. With a request for addr 2 outstanding (WAIT), redirect=1, redirect_pc=16'h0040.
   -> count=0, out_valid=0; the pending response is discarded; the next mem_req has addr 16'h0040, issued only after that mem_ready; the first output is pc 16'h0040.
4. redirect (redirect_pc=16'h0040) in the same cycle as mem_ready for addr 5.
   -> no push; state IDLE; next mem_req addr 16'h0040 two cycles later.
5. stop=1 while WAIT for addr 1.
   -> the addr-1 word is pushed, then no mem_req while stop=1 and entries are retained.
   -> stop=0: mem_req addr 2 after IDLE->REQ.
6. rst_n=0 for one cycle while in WAIT with 3 entries buffered.
   -> count=0, out_valid=0, mem_req=0; a stale mem_ready in IDLE is ignored; the next mem_req has addr RESET_PC.
